// File: rtl/vproc_div_arb_pkg.sv
// Shared helpers for the divider arbiter: index and counter width calculations
// used by the arbiter top and its tag FIFO.
package vproc_div_arb_pkg;

    // Width of an index into n entries; never collapses to zero bits.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Width of an occupancy counter that must be able to hold the value depth.
    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/vproc_div_tag_fifo.sv
// In-order tag FIFO recording which requester owns each operation inside the
// divider pipeline. Head is read combinationally so results route with zero latency.
module vproc_div_tag_fifo
    import vproc_div_arb_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 1,
    localparam int unsigned PTR_W = idx_width(DEPTH),
    localparam int unsigned CNT_W = cnt_width(DEPTH)
) (
    input  logic             clk_i,
    input  logic             async_rst_ni,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] head_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W-1:0] wr_ptr_next;
    logic [PTR_W-1:0] rd_ptr_next;
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_next;
    logic             push_en;
    logic             pop_en;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem[rd_ptr_q];

    // Guard internally as well so a misbehaving caller cannot corrupt occupancy.
    assign push_en = push_i & ~full_o;
    assign pop_en  = pop_i & ~empty_o;

    assign wr_ptr_next = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
    assign rd_ptr_next = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);

    always_comb begin
        count_next = count_q;
        if (push_en && !pop_en) begin
            count_next = count_q + CNT_W'(1);
        end else if (pop_en && !push_en) begin
            count_next = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i or negedge async_rst_ni) begin
        if (!async_rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_en) begin
                wr_ptr_q <= wr_ptr_next;
            end
            if (pop_en) begin
                rd_ptr_q <= rd_ptr_next;
            end
            count_q <= count_next;
        end
    end

    // Storage needs no reset: entries are only read once the counter says they are valid.
    always_ff @(posedge clk_i) begin
        if (push_en) begin
            mem[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/vproc_div_arb.sv
// Round-robin arbiter sharing one in-order divider pipeline among N_REQ requesters;
// a tag FIFO remembers the owner of each issued operation to steer results back.
module vproc_div_arb
    import vproc_div_arb_pkg::*;
#(
    parameter int unsigned N_REQ        = 2,
    parameter int unsigned DIV_OP_W     = 64,
    parameter int unsigned MAX_INFLIGHT = 4,
    parameter type         CTRL_T       = logic
) (
    input  logic                  clk_i,
    input  logic                  async_rst_ni,

    input  logic [N_REQ-1:0]      req_valid_i,
    output logic [N_REQ-1:0]      req_ready_o,
    input  CTRL_T                 req_ctrl_i [N_REQ],
    input  logic [DIV_OP_W-1:0]   req_op1_i  [N_REQ],
    input  logic [DIV_OP_W-1:0]   req_op2_i  [N_REQ],
    input  logic [DIV_OP_W/8-1:0] req_mask_i [N_REQ],

    output logic                  div_in_valid_o,
    input  logic                  div_in_ready_i,
    output CTRL_T                 div_in_ctrl_o,
    output logic [DIV_OP_W-1:0]   div_in_op1_o,
    output logic [DIV_OP_W-1:0]   div_in_op2_o,
    output logic [DIV_OP_W/8-1:0] div_in_mask_o,

    input  logic                  div_out_valid_i,
    output logic                  div_out_ready_o,
    input  CTRL_T                 div_out_ctrl_i,
    input  logic [DIV_OP_W-1:0]   div_out_res_i,
    input  logic [DIV_OP_W/8-1:0] div_out_mask_i,

    output logic [N_REQ-1:0]      rsp_valid_o,
    input  logic [N_REQ-1:0]      rsp_ready_i,
    output CTRL_T                 rsp_ctrl_o,
    output logic [DIV_OP_W-1:0]   rsp_res_o,
    output logic [DIV_OP_W/8-1:0] rsp_mask_o,

    output logic                  idle_o
);

    localparam int unsigned TAG_W = idx_width(N_REQ);
    localparam int unsigned CNT_W = cnt_width(MAX_INFLIGHT);

    logic [TAG_W-1:0] rr_q;
    logic             lock_q;
    logic [TAG_W-1:0] lock_idx_q;

    logic [TAG_W-1:0] grant;
    logic [TAG_W-1:0] grant_inc;
    logic [TAG_W:0]   cand_sum;
    logic             found;

    logic             fifo_full;
    logic             fifo_empty;
    logic [TAG_W-1:0] fifo_head;
    logic [CNT_W-1:0] fifo_count;
    logic             issue;
    logic             stall;
    logic             pop;
    logic [N_REQ-1:0] head_sel;

    // Scan from rr_q with wrap-around; a stalled grant stays locked until it handshakes.
    always_comb begin
        grant    = rr_q;
        found    = 1'b0;
        cand_sum = '0;
        if (lock_q) begin
            grant = lock_idx_q;
        end else begin
            for (int k = 0; k < N_REQ; k++) begin
                cand_sum = {1'b0, rr_q} + (TAG_W + 1)'(k);
                if (cand_sum >= (TAG_W + 1)'(N_REQ)) begin
                    cand_sum = cand_sum - (TAG_W + 1)'(N_REQ);
                end
                if (!found && req_valid_i[cand_sum[TAG_W-1:0]]) begin
                    grant = cand_sum[TAG_W-1:0];
                    found = 1'b1;
                end
            end
        end
    end

    assign grant_inc = (grant == TAG_W'(N_REQ - 1)) ? '0 : grant + TAG_W'(1);

    // A full FIFO blocks issue even when a pop is under way, keeping div_out off the div_in path.
    assign div_in_valid_o = (|req_valid_i) & ~fifo_full;
    assign div_in_ctrl_o  = req_ctrl_i[grant];
    assign div_in_op1_o   = req_op1_i[grant];
    assign div_in_op2_o   = req_op2_i[grant];
    assign div_in_mask_o  = req_mask_i[grant];

    assign issue = div_in_valid_o & div_in_ready_i;
    assign stall = div_in_valid_o & ~div_in_ready_i;

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_req
        assign req_ready_o[gi] = (grant == TAG_W'(gi)) & div_in_ready_i & ~fifo_full;
        assign rsp_valid_o[gi] = div_out_valid_i & ~fifo_empty & (fifo_head == TAG_W'(gi));
        assign head_sel[gi]    = rsp_ready_i[gi] & (fifo_head == TAG_W'(gi));
    end

    assign div_out_ready_o = ~fifo_empty & (|head_sel);
    assign pop             = div_out_valid_i & div_out_ready_o;

    assign rsp_ctrl_o = div_out_ctrl_i;
    assign rsp_res_o  = div_out_res_i;
    assign rsp_mask_o = div_out_mask_i;

    assign idle_o = fifo_empty & ~(|req_valid_i);

    always_ff @(posedge clk_i or negedge async_rst_ni) begin
        if (!async_rst_ni) begin
            rr_q       <= '0;
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
        end else if (issue) begin
            rr_q   <= grant_inc;
            lock_q <= 1'b0;
        end else if (stall) begin
            lock_q     <= 1'b1;
            lock_idx_q <= grant;
        end
    end

    vproc_div_tag_fifo #(
        .DEPTH (MAX_INFLIGHT),
        .WIDTH (TAG_W)
    ) u_tag_fifo (
        .clk_i        (clk_i),
        .async_rst_ni (async_rst_ni),
        .push_i       (issue),
        .pop_i        (pop),
        .data_i       (grant),
        .head_o       (fifo_head),
        .full_o       (fifo_full),
        .empty_o      (fifo_empty),
        .count_o      (fifo_count)
    );

    // A result with no recorded owner means the divider was not flushed with this block.
    a_no_orphan_result: assert property (@(posedge clk_i) disable iff (!async_rst_ni)
        div_out_valid_i |-> !fifo_empty);

    a_locked_req_holds: assert property (@(posedge clk_i) disable iff (!async_rst_ni)
        lock_q |-> req_valid_i[lock_idx_q]);

    a_count_bound: assert property (@(posedge clk_i) disable iff (!async_rst_ni)
        fifo_count <= CNT_W'(MAX_INFLIGHT));

endmodule

// File: tb/tb_vproc_div_arb.sv
// Bench for vproc_div_arb: random and directed traffic against an ownership-queue
// reference model plus a simple in-order divider stand-in.
module tb_vproc_div_arb;

    localparam int N    = 2;
    localparam int W    = 32;
    localparam int MW   = W / 8;
    localparam int MAXF = 4;

    typedef logic [7:0] ctrl_t;
    typedef struct packed {
        ctrl_t         ctrl;
        logic [W-1:0]  res;
        logic [MW-1:0] mask;
    } item_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [N-1:0]  req_valid = '0;
    logic [N-1:0]  req_ready;
    ctrl_t         req_ctrl [N];
    logic [W-1:0]  req_op1  [N];
    logic [W-1:0]  req_op2  [N];
    logic [MW-1:0] req_mask [N];
    logic          div_in_valid;
    logic          div_in_ready = 1'b0;
    ctrl_t         div_in_ctrl;
    logic [W-1:0]  div_in_op1;
    logic [W-1:0]  div_in_op2;
    logic [MW-1:0] div_in_mask;
    logic          div_out_valid = 1'b0;
    logic          div_out_ready;
    ctrl_t         div_out_ctrl = '0;
    logic [W-1:0]  div_out_res = '0;
    logic [MW-1:0] div_out_mask = '0;
    logic [N-1:0]  rsp_valid;
    logic [N-1:0]  rsp_ready = '0;
    ctrl_t         rsp_ctrl;
    logic [W-1:0]  rsp_res;
    logic [MW-1:0] rsp_mask;
    logic          idle;

    vproc_div_arb #(
        .N_REQ        (N),
        .DIV_OP_W     (W),
        .MAX_INFLIGHT (MAXF),
        .CTRL_T       (ctrl_t)
    ) dut (
        .clk_i           (clk),
        .async_rst_ni    (rst_n),
        .req_valid_i     (req_valid),
        .req_ready_o     (req_ready),
        .req_ctrl_i      (req_ctrl),
        .req_op1_i       (req_op1),
        .req_op2_i       (req_op2),
        .req_mask_i      (req_mask),
        .div_in_valid_o  (div_in_valid),
        .div_in_ready_i  (div_in_ready),
        .div_in_ctrl_o   (div_in_ctrl),
        .div_in_op1_o    (div_in_op1),
        .div_in_op2_o    (div_in_op2),
        .div_in_mask_o   (div_in_mask),
        .div_out_valid_i (div_out_valid),
        .div_out_ready_o (div_out_ready),
        .div_out_ctrl_i  (div_out_ctrl),
        .div_out_res_i   (div_out_res),
        .div_out_mask_i  (div_out_mask),
        .rsp_valid_o     (rsp_valid),
        .rsp_ready_i     (rsp_ready),
        .rsp_ctrl_o      (rsp_ctrl),
        .rsp_res_o       (rsp_res),
        .rsp_mask_o      (rsp_mask),
        .idle_o          (idle)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: round-robin pointer, lock, owner queue; divider stand-in queue.
    int    m_rr = 0;
    bit    m_lock = 0;
    int    m_lock_idx = 0;
    int    own_q[$];
    item_t div_q[$];
    bit    out_en = 0;

    // Per-cycle expected (e_*) and observed (o_*) values.
    bit            e_div_valid, e_out_ready, e_idle;
    int            e_grant, e_acc;
    logic [N-1:0]  e_req_ready, e_rsp_valid;
    logic [W-1:0]  e_op1, e_op2, e_rsp_res;
    ctrl_t         e_ctrl;
    logic [MW-1:0] e_mask;
    logic          o_div_valid, o_out_ready, o_idle;
    logic [N-1:0]  o_req_ready, o_rsp_valid;
    logic [W-1:0]  o_op1, o_rsp_res;
    ctrl_t         o_ctrl;
    logic [MW-1:0] o_rsp_mask;

    function automatic logic [W-1:0] ref_result(input logic [W-1:0] a, input logic [W-1:0] b);
        return (b == '0) ? '1 : a / b;
    endfunction

    function automatic logic [N-1:0] onehot(input int i);
        logic [N-1:0] v;
        v = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    function automatic int model_grant();
        if (m_lock) return m_lock_idx;
        for (int k = 0; k < N; k++) begin
            if (req_valid[(m_rr + k) % N]) return (m_rr + k) % N;
        end
        return m_rr;
    endfunction

    task automatic new_op(input int i);
        req_ctrl[i] = ctrl_t'($urandom);
        req_op1[i]  = $urandom;
        req_op2[i]  = $urandom_range(0, 7) == 0 ? '0 : W'($urandom_range(1, 5000));
        req_mask[i] = MW'($urandom);
    endtask

    task automatic model_reset();
        m_rr = 0;
        m_lock = 0;
        m_lock_idx = 0;
        own_q.delete();
        div_q.delete();
    endtask

    // One clock: present divider output, sample at negedge, advance the model at posedge.
    task automatic tick();
        bit full, empty, issue, pop;
        item_t it;
        div_out_valid = out_en && (div_q.size() > 0);
        if (div_q.size() > 0) begin
            div_out_ctrl = div_q[0].ctrl;
            div_out_res  = div_q[0].res;
            div_out_mask = div_q[0].mask;
        end
        @(negedge clk);
        full        = (own_q.size() == MAXF);
        empty       = (own_q.size() == 0);
        e_grant     = model_grant();
        e_div_valid = (|req_valid) && !full;
        e_req_ready = (div_in_ready && !full) ? onehot(e_grant) : '0;
        e_rsp_valid = (div_out_valid && !empty) ? onehot(own_q[0]) : '0;
        e_out_ready = !empty && rsp_ready[own_q[0]];
        e_idle      = empty && !(|req_valid);
        e_op1       = req_op1[e_grant];
        e_op2       = req_op2[e_grant];
        e_ctrl      = req_ctrl[e_grant];
        e_mask      = req_mask[e_grant];
        e_rsp_res   = (div_q.size() > 0) ? div_q[0].res : '0;
        o_div_valid = div_in_valid;
        o_req_ready = req_ready;
        o_op1       = div_in_op1;
        o_ctrl      = div_in_ctrl;
        o_rsp_valid = rsp_valid;
        o_out_ready = div_out_ready;
        o_idle      = idle;
        o_rsp_res   = rsp_res;
        o_rsp_mask  = rsp_mask;
        @(posedge clk);
        issue = e_div_valid && div_in_ready;
        pop   = div_out_valid && e_out_ready;
        e_acc = -1;
        if (pop) begin
            own_q.delete(0);
            div_q.delete(0);
        end
        if (issue) begin
            it.ctrl = e_ctrl;
            it.res  = ref_result(e_op1, e_op2);
            it.mask = e_mask;
            own_q.push_back(e_grant);
            div_q.push_back(it);
            m_rr   = (e_grant + 1) % N;
            m_lock = 0;
            e_acc  = e_grant;
        end else if (e_div_valid) begin
            m_lock     = 1;
            m_lock_idx = e_grant;
        end
        #1;
    endtask

    task automatic drain();
        req_valid = '0;
        out_en    = 1;
        rsp_ready = '1;
        for (int c = 0; c < 20 && own_q.size() > 0; c++) tick();
        n_checks++;
        if (own_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain_timeout: in_flight=%0d required=0", own_q.size());
        end
        out_en = 0;
    endtask

    task automatic test_reset();
        div_in_ready = 1'b0;
        req_valid = '0;
        @(negedge clk);
        n_checks++;
        if ({div_in_valid, div_out_ready, rsp_valid, idle} !== 5'b00001) begin
            n_fail++;
            $display("FAIL reset_outputs: got=%b required=00001", {div_in_valid, div_out_ready, rsp_valid, idle});
        end
        $display("reset: outputs=%b", {div_in_valid, div_out_ready, rsp_valid, idle});
        req_valid = 2'b10;
        div_in_ready = 1'b1;
        #1;
        n_checks++;
        if ({div_in_valid, idle, req_ready} !== 4'b1010) begin
            n_fail++;
            $display("FAIL reset_comb_req: got=%b required=1010", {div_in_valid, idle, req_ready});
        end
        req_valid = '0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_single_b2b();
        logic [W-1:0] a [3];
        logic [W-1:0] b [3];
        out_en = 0;
        div_in_ready = 1;
        rsp_ready = '1;
        for (int k = 0; k < 3; k++) begin
            new_op(0);
            a[k] = req_op1[0];
            b[k] = req_op2[0];
            req_valid = 2'b01;
            tick();
            n_checks++;
            if (o_req_ready !== 2'b01 || o_op1 !== a[k] || o_div_valid !== 1'b1) begin
                n_fail++;
                $display("FAIL b2b_issue%0d: ready=%b op1=%h required ready=01 op1=%h", k, o_req_ready, o_op1, a[k]);
            end
            $display("b2b issue %0d: op1=%h ready=%b", k, o_op1, o_req_ready);
        end
        req_valid = '0;
        out_en = 1;
        for (int k = 0; k < 3; k++) begin
            tick();
            n_checks++;
            if (o_rsp_valid !== 2'b01 || o_rsp_res !== ref_result(a[k], b[k])) begin
                n_fail++;
                $display("FAIL b2b_result%0d: valid=%b res=%h required valid=01 res=%h", k, o_rsp_valid, o_rsp_res, ref_result(a[k], b[k]));
            end
            $display("b2b result %0d: valid=%b res=%h", k, o_rsp_valid, o_rsp_res);
        end
        drain();
    endtask

    task automatic test_alternate();
        int prev = -1;
        new_op(0);
        new_op(1);
        req_valid = 2'b11;
        div_in_ready = 1;
        out_en = 1;
        rsp_ready = '1;
        for (int c = 0; c < 8; c++) begin
            tick();
            n_checks++;
            if (o_req_ready !== e_req_ready || o_rsp_valid !== e_rsp_valid || e_acc == prev) begin
                n_fail++;
                $display("FAIL alt_cycle%0d: ready=%b rsp=%b required ready=%b rsp=%b (prev grant %0d)", c, o_req_ready, o_rsp_valid, e_req_ready, e_rsp_valid, prev);
            end
            $display("alt cycle %0d: grant=%0d ready=%b rsp=%b", c, e_grant, o_req_ready, o_rsp_valid);
            prev = e_acc;
            if (e_acc >= 0) new_op(e_acc);
        end
        drain();
    endtask

    task automatic test_stall();
        logic [W-1:0] b_op, c_op;
        div_in_ready = 1;
        new_op(0);
        req_valid = 2'b01;
        tick();
        new_op(0);
        b_op = req_op1[0];
        div_in_ready = 0;
        tick();
        new_op(1);
        c_op = req_op1[1];
        req_valid = 2'b11;
        for (int c = 0; c < 3; c++) begin
            tick();
            n_checks++;
            if (o_div_valid !== 1'b1 || o_op1 !== b_op || o_req_ready !== 2'b00) begin
                n_fail++;
                $display("FAIL stall_hold%0d: valid=%b op1=%h ready=%b required 1 %h 00", c, o_div_valid, o_op1, o_req_ready, b_op);
            end
            $display("stall cycle %0d: op1=%h ready=%b", c, o_op1, o_req_ready);
        end
        div_in_ready = 1;
        tick();
        n_checks++;
        if (o_req_ready !== 2'b01 || o_op1 !== b_op) begin
            n_fail++;
            $display("FAIL stall_release: ready=%b op1=%h required 01 %h", o_req_ready, o_op1, b_op);
        end
        req_valid = 2'b10;
        tick();
        n_checks++;
        if (o_req_ready !== 2'b10 || o_op1 !== c_op) begin
            n_fail++;
            $display("FAIL stall_next: ready=%b op1=%h required 10 %h", o_req_ready, o_op1, c_op);
        end
        $display("stall: req1 issued op1=%h", o_op1);
        drain();
    endtask

    task automatic test_full();
        int issues = 0;
        new_op(0);
        new_op(1);
        req_valid = 2'b11;
        div_in_ready = 1;
        out_en = 0;
        rsp_ready = '1;
        for (int c = 0; c < 7; c++) begin
            tick();
            if (o_div_valid && |o_req_ready) issues++;
            if (c >= 4) begin
                n_checks++;
                if (o_div_valid !== 1'b0) begin
                    n_fail++;
                    $display("FAIL full_block%0d: div_in_valid=%b required 0", c, o_div_valid);
                end
            end
            if (e_acc >= 0) new_op(e_acc);
        end
        n_checks++;
        if (issues != MAXF) begin
            n_fail++;
            $display("FAIL full_issues: got=%0d required=%0d", issues, MAXF);
        end
        $display("full: %0d issues before block", issues);
        out_en = 1;
        tick();
        n_checks++;
        if (o_div_valid !== 1'b0 || o_out_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL full_pop_cycle: div_in_valid=%b out_ready=%b required 0 1", o_div_valid, o_out_ready);
        end
        tick();
        n_checks++;
        if (o_div_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL full_after_pop: div_in_valid=%b required 1", o_div_valid);
        end
        drain();
    endtask

    task automatic test_rsp_backpressure();
        logic [W-1:0] exp_res;
        new_op(1);
        exp_res = ref_result(req_op1[1], req_op2[1]);
        req_valid = 2'b10;
        div_in_ready = 1;
        out_en = 0;
        tick();
        req_valid = '0;
        rsp_ready = 2'b01;
        out_en = 1;
        for (int c = 0; c < 3; c++) begin
            tick();
            n_checks++;
            if (o_rsp_valid !== 2'b10 || o_out_ready !== 1'b0 || o_rsp_res !== exp_res) begin
                n_fail++;
                $display("FAIL bp_hold%0d: rsp=%b out_ready=%b res=%h required 10 0 %h", c, o_rsp_valid, o_out_ready, o_rsp_res, exp_res);
            end
            $display("backpressure cycle %0d: rsp=%b out_ready=%b", c, o_rsp_valid, o_out_ready);
        end
        rsp_ready = 2'b11;
        tick();
        n_checks++;
        if (o_out_ready !== 1'b1 || o_rsp_valid !== 2'b10) begin
            n_fail++;
            $display("FAIL bp_release: out_ready=%b rsp=%b required 1 10", o_out_ready, o_rsp_valid);
        end
        tick();
        n_checks++;
        if (o_idle !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_idle: idle=%b required 1", o_idle);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            div_in_ready = ($urandom_range(0, 3) != 0);
            out_en       = ($urandom_range(0, 2) != 0);
            rsp_ready    = N'($urandom);
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i] && $urandom_range(0, 1) == 1) begin
                    new_op(i);
                    req_valid[i] = 1'b1;
                end
            end
            tick();
            n_checks++;
            if ({o_div_valid, o_req_ready, o_rsp_valid, o_out_ready, o_idle} !==
                {e_div_valid, e_req_ready, e_rsp_valid, e_out_ready, e_idle}) begin
                n_fail++;
                $display("FAIL rand_ctl%0d: got=%b required=%b", c,
                         {o_div_valid, o_req_ready, o_rsp_valid, o_out_ready, o_idle},
                         {e_div_valid, e_req_ready, e_rsp_valid, e_out_ready, e_idle});
            end
            if (e_div_valid) begin
                n_checks++;
                if (o_op1 !== e_op1 || o_ctrl !== e_ctrl) begin
                    n_fail++;
                    $display("FAIL rand_data%0d: op1=%h ctrl=%h required %h %h", c, o_op1, o_ctrl, e_op1, e_ctrl);
                end
            end
            if (e_rsp_valid != '0) begin
                n_checks++;
                if (o_rsp_res !== e_rsp_res) begin
                    n_fail++;
                    $display("FAIL rand_rsp%0d: res=%h required %h", c, o_rsp_res, e_rsp_res);
                end
            end
            $display("rand %0d: grant=%0d acc=%0d rsp=%b inflight=%0d", c, e_grant, e_acc, o_rsp_valid, own_q.size());
            if (e_acc >= 0) begin
                if ($urandom_range(0, 1) == 1) new_op(e_acc);
                else req_valid[e_acc] = 1'b0;
            end
        end
        drain();
    endtask

    task automatic test_reset_midflight();
        new_op(0);
        req_valid = 2'b01;
        div_in_ready = 1;
        out_en = 0;
        tick();
        new_op(0);
        tick();
        req_valid = '0;
        div_out_valid = 1'b1;
        div_out_res = div_q[0].res;
        #1;
        n_checks++;
        if (rsp_valid !== 2'b01) begin
            n_fail++;
            $display("FAIL midrst_pre: rsp=%b required 01", rsp_valid);
        end
        #1 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({rsp_valid, div_out_ready, idle, div_in_valid} !== 5'b00010) begin
            n_fail++;
            $display("FAIL midrst_clear: got=%b required=00010", {rsp_valid, div_out_ready, idle, div_in_valid});
        end
        $display("mid-flight reset: rsp=%b idle=%b", rsp_valid, idle);
        div_out_valid = 1'b0;
        model_reset();
        @(posedge clk);
        #1 rst_n = 1'b1;
        new_op(0);
        new_op(1);
        req_valid = 2'b11;
        #1;
        n_checks++;
        if (req_ready !== 2'b01) begin
            n_fail++;
            $display("FAIL midrst_rr: ready=%b required 01", req_ready);
        end
        tick();
        drain();
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            new_op(i);
        end
        test_reset();
        test_single_b2b();
        test_alternate();
        test_stall();
        test_full();
        test_rsp_backpressure();
        test_random();
        test_reset_midflight();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

endmodule
